// File: rtl/peg_l2_rs_pkg.sv
// Shared definitions for the GMII reconciliation-sublayer transmit path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the TX FSM state encoding and the fixed Ethernet framing constants
// used by peg_l2_rs_tx.

package peg_l2_rs_pkg;

  // The encoding is visible on rs_tx_fsm_state, so the values are pinned.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SFD   = 3'd2,
    ST_DATA  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_IPG   = 3'd5
  } rs_tx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         PREAMBLE_LEN  = 7;
  localparam int         MIN_IPG       = 12;

endpackage

// File: rtl/peg_l2_rs_tx.sv
// GMII transmit reconciliation: wraps MAC frame beats in preamble/SFD, enforces IPG.
// Latency: a beat accepted at cycle k is on gmii_txd at k+1; a frame start seen at t gives the first preamble byte at t+1.
// Backpressure: rs_tx_ready is a pure function of state (high in SFD/DATA/FLUSH); an underrun aborts the frame and flushes it.
//
// Ports:
//   clk, rst                   single clock, synchronous active-high reset
//   config_rs_tx_en            allows a new frame to start (only looked at in IDLE)
//   config_rs_tx_ipg           inter-packet gap in byte times, floored at MIN_IPG
//   rs_tx_valid/sop/eop/error  upstream beat qualifiers, rs_tx_data is the byte
//   rs_tx_ready                upstream beat accepted when valid & ready
//   gmii_txd/tx_en/tx_er       registered GMII transmit outputs
//   rs_tx_fsm_state            current FSM state encoding
//   rs_tx_underrun_cnt         saturating count of frames aborted by underrun

module peg_l2_rs_tx
  import peg_l2_rs_pkg::*;
#(
  parameter int PKT_DATA_W = 8,
  parameter int IPG_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  config_rs_tx_en,
  input  logic [IPG_W-1:0]      config_rs_tx_ipg,
  input  logic                  rs_tx_valid,
  input  logic                  rs_tx_sop,
  input  logic                  rs_tx_eop,
  input  logic                  rs_tx_error,
  input  logic [PKT_DATA_W-1:0] rs_tx_data,
  output logic                  rs_tx_ready,
  output logic [7:0]            gmii_txd,
  output logic                  gmii_tx_en,
  output logic                  gmii_tx_er,
  output logic [2:0]            rs_tx_fsm_state,
  output logic [15:0]           rs_tx_underrun_cnt
);

  // The shared down-counter must hold both PREAMBLE_LEN-1 and the largest
  // configurable gap, and at least MIN_IPG-1.
  localparam int CNT_W = (IPG_W > 4) ? IPG_W : 4;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_PRE_TOP = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MIN_IPG = CNT_W'(MIN_IPG);

  rs_tx_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       txd_q, txd_d;
  logic             tx_en_q, tx_en_d;
  logic             tx_er_q, tx_er_d;
  logic [15:0]      ucnt_q, ucnt_d;

  logic [CNT_W-1:0] ipg_ext;
  logic [CNT_W-1:0] ipg_top;
  logic             beat_acc;

  // Gap counter start value. The counter is loaded on the cycle the last
  // transmitted symbol is registered and reaches IDLE after exactly
  // max(cfg, MIN_IPG) cycles of tx_en=0 on the wire.
  assign ipg_ext = CNT_W'(config_rs_tx_ipg);
  assign ipg_top = (ipg_ext < CNT_MIN_IPG) ? (CNT_MIN_IPG - CNT_ONE)
                                           : (ipg_ext - CNT_ONE);

  assign rs_tx_ready = (state_q == ST_SFD) || (state_q == ST_DATA) ||
                       (state_q == ST_FLUSH);
  assign beat_acc    = rs_tx_valid && rs_tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      txd_q   <= 8'h00;
      tx_en_q <= 1'b0;
      tx_er_q <= 1'b0;
      ucnt_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
      tx_en_q <= tx_en_d;
      tx_er_q <= tx_er_d;
      ucnt_q  <= ucnt_d;
    end
  end

  always_comb begin
    // Default: hold FSM/counters, drive an idle wire (tx_en=0 implies txd=0, er=0).
    state_d = state_q;
    cnt_d   = cnt_q;
    txd_d   = 8'h00;
    tx_en_d = 1'b0;
    tx_er_d = 1'b0;
    ucnt_d  = ucnt_q;

    case (state_q)
      ST_IDLE: begin
        // The sop beat is only peeked here; it is consumed in SFD once the
        // preamble has gone out. A valid beat without sop just waits.
        if (config_rs_tx_en && rs_tx_valid && rs_tx_sop) begin
          state_d = ST_PRE;
          cnt_d   = CNT_PRE_TOP;
          txd_d   = PREAMBLE_BYTE;
          tx_en_d = 1'b1;
        end
      end

      ST_PRE: begin
        // The first preamble byte was registered from IDLE, so the last PRE
        // cycle registers the SFD instead of another 0x55.
        tx_en_d = 1'b1;
        if (cnt_q == '0) begin
          txd_d   = SFD_BYTE;
          state_d = ST_SFD;
        end else begin
          txd_d = PREAMBLE_BYTE;
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_SFD, ST_DATA: begin
        if (rs_tx_valid) begin
          txd_d   = rs_tx_data[7:0];
          tx_en_d = 1'b1;
          // A second sop inside a frame is sent on, but flagged as errored.
          tx_er_d = rs_tx_error || (rs_tx_sop && (state_q == ST_DATA));
          if (rs_tx_eop) begin
            state_d = ST_IPG;
            cnt_d   = ipg_top;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          // Underrun: one error symbol, then the rest of the frame is dropped.
          // The gap countdown starts now so FLUSH time counts toward the IPG.
          txd_d   = 8'h00;
          tx_en_d = 1'b1;
          tx_er_d = 1'b1;
          state_d = ST_FLUSH;
          cnt_d   = ipg_top;
          if (ucnt_q != 16'hFFFF) begin
            ucnt_d = ucnt_q + 16'd1;
          end
        end
      end

      ST_FLUSH: begin
        // Keep the gap countdown running while draining; it parks at zero.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        if (beat_acc && rs_tx_eop) begin
          state_d = ST_IPG;
        end
      end

      ST_IPG: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign gmii_txd           = txd_q;
  assign gmii_tx_en         = tx_en_q;
  assign gmii_tx_er         = tx_er_q;
  assign rs_tx_fsm_state    = state_q;
  assign rs_tx_underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_peg_l2_rs_tx.sv
// Directed bench for peg_l2_rs_tx: GMII symbols checked against a scoreboard queue.
// Latency: expected symbols are queued when a frame is issued, popped on every tx_en=1 cycle.
// Backpressure: the upstream model honours rs_tx_ready and holds its beat until accepted.

module tb_peg_l2_rs_tx;

  logic        clk;
  logic        rst;
  logic        config_rs_tx_en;
  logic [7:0]  config_rs_tx_ipg;
  logic        rs_tx_valid;
  logic        rs_tx_sop;
  logic        rs_tx_eop;
  logic        rs_tx_error;
  logic [7:0]  rs_tx_data;
  logic        rs_tx_ready;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic [2:0]  rs_tx_fsm_state;
  logic [15:0] rs_tx_underrun_cnt;

  peg_l2_rs_tx #(
    .PKT_DATA_W (8),
    .IPG_W      (8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .config_rs_tx_en    (config_rs_tx_en),
    .config_rs_tx_ipg   (config_rs_tx_ipg),
    .rs_tx_valid        (rs_tx_valid),
    .rs_tx_sop          (rs_tx_sop),
    .rs_tx_eop          (rs_tx_eop),
    .rs_tx_error        (rs_tx_error),
    .rs_tx_data         (rs_tx_data),
    .rs_tx_ready        (rs_tx_ready),
    .gmii_txd           (gmii_txd),
    .gmii_tx_en         (gmii_tx_en),
    .gmii_tx_er         (gmii_tx_er),
    .rs_tx_fsm_state    (rs_tx_fsm_state),
    .rs_tx_underrun_cnt (rs_tx_underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Scoreboard entries are {tx_er, txd}.
  logic [8:0] exp_q[$];

  logic prev_en  = 1'b0;
  int   zero_run = 0;
  int   last_gap = -1;
  int   rise_cyc = -1;
  int   fall_cyc = -1;
  int   start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    logic [8:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (gmii_tx_en) begin
      if (!prev_en) begin
        last_gap = zero_run;
        rise_cyc = cyc;
        zero_run = 0;
      end
      if (exp_q.size() == 0) begin
        chk("queue_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("tx_symbol", 32'({gmii_tx_er, gmii_txd}), 32'(e));
      end
    end else begin
      if (prev_en) fall_cyc = cyc;
      zero_run++;
      chk("idle_txd_er", 32'({gmii_tx_er, gmii_txd}), 32'd0);
    end
    prev_en = gmii_tx_en;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_inputs();
    rs_tx_valid = 1'b0;
    rs_tx_sop   = 1'b0;
    rs_tx_eop   = 1'b0;
    rs_tx_error = 1'b0;
    rs_tx_data  = 8'h00;
  endtask

  // Issue one frame of len bytes (byte b = base+b). Options (0 = unused):
  // err_idx marks a beat errored, sop2_idx raises sop mid-frame, drop_after
  // idles valid for one cycle after that beat, rst_after pulses reset after
  // that beat, en_off_idx drops config_rs_tx_en after that beat.
  task automatic send_frame(input int len, input logic [7:0] base, input int err_idx,
                            input int sop2_idx, input int drop_after, input int rst_after,
                            input int en_off_idx);
    int  i;
    int  guard;
    bit  dropped;
    bit  acc;
    bit  was_rst;
    for (int p = 0; p < 7; p++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    for (int b = 1; b <= len; b++) begin
      if (rst_after > 0 && b > rst_after) break;
      if (drop_after > 0 && b > drop_after) begin
        exp_q.push_back({1'b1, 8'h00});
        break;
      end
      exp_q.push_back({((b == err_idx) || (b == sop2_idx)), 8'(base + 8'(b))});
    end

    i       = 1;
    guard   = 0;
    dropped = 1'b0;
    was_rst = 1'b0;
    while (i <= len && guard < 600) begin
      rs_tx_valid = 1'b1;
      rs_tx_sop   = (i == 1) || (i == sop2_idx);
      rs_tx_eop   = (i == len);
      rs_tx_error = (i == err_idx);
      rs_tx_data  = 8'(base + 8'(i));
      acc = rs_tx_ready;
      tick();
      guard++;
      if (acc) begin
        if (i == en_off_idx) config_rs_tx_en = 1'b0;
        if (i == rst_after) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          was_rst = 1'b1;
          break;
        end
        if (i == drop_after && !dropped) begin
          clear_inputs();
          tick();
          guard++;
          dropped = 1'b1;
        end
        i++;
      end
    end
    clear_inputs();
    if (!was_rst) chk("frame_accepted", 32'(i), 32'(len + 1));
  endtask

  initial begin
    rst              = 1'b1;
    config_rs_tx_en  = 1'b1;
    config_rs_tx_ipg = 8'd12;
    clear_inputs();

    // Reset state
    idle(3);
    chk("rst_tx_en", 32'(gmii_tx_en), 32'd0);
    chk("rst_txd", 32'(gmii_txd), 32'd0);
    chk("rst_state", 32'(rs_tx_fsm_state), 32'd0);
    chk("rst_ucnt", 32'(rs_tx_underrun_cnt), 32'd0);
    chk("rst_ready", 32'(rs_tx_ready), 32'd0);
    rst = 1'b0;
    idle(3);

    // 64-byte frame, ipg 12: preamble t+1..t+7, SFD t+8, data t+9..t+72
    config_rs_tx_ipg = 8'd12;
    start = cyc;
    send_frame(64, 8'h00, 0, 0, 0, 0, 0);
    idle(20);
    chk("f64_rise", 32'(rise_cyc), 32'(start + 1));
    chk("f64_fall", 32'(fall_cyc), 32'(start + 73));

    // Back-to-back frames with valid held; the gap follows the ipg
    // in force when the previous frame's eop was accepted.
    config_rs_tx_ipg = 8'd12;
    send_frame(16, 8'h40, 0, 0, 0, 0, 0);
    config_rs_tx_ipg = 8'd20;
    send_frame(16, 8'h80, 0, 0, 0, 0, 0);
    chk("gap_ipg12", 32'(last_gap), 32'd12);
    config_rs_tx_ipg = 8'd5;
    send_frame(20, 8'hA0, 0, 0, 0, 0, 0);
    chk("gap_ipg20", 32'(last_gap), 32'd20);
    send_frame(10, 8'hC0, 0, 0, 0, 0, 0);
    chk("gap_ipg5_floor", 32'(last_gap), 32'd12);
    config_rs_tx_ipg = 8'd12;
    idle(20);

    // Underrun after data byte 10
    start = cyc;
    send_frame(64, 8'h10, 0, 0, 10, 0, 0);
    idle(15);
    chk("ur_rise", 32'(rise_cyc), 32'(start + 1));
    chk("ur_fall", 32'(fall_cyc), 32'(start + 20));
    chk("ur_cnt", 32'(rs_tx_underrun_cnt), 32'd1);
    start = cyc;
    send_frame(16, 8'h20, 0, 0, 0, 0, 0);
    idle(20);
    chk("post_ur_rise", 32'(rise_cyc), 32'(start + 1));
    chk("post_ur_fall", 32'(fall_cyc), 32'(start + 25));
    chk("post_ur_cnt", 32'(rs_tx_underrun_cnt), 32'd1);

    // Errored beat 30 only
    send_frame(64, 8'h30, 30, 0, 0, 0, 0);
    idle(20);

    // sop inside the frame, and config_rs_tx_en dropped mid-frame
    start = cyc;
    send_frame(24, 8'h50, 0, 12, 0, 0, 5);
    idle(20);
    config_rs_tx_en = 1'b1;
    chk("sop2_fall", 32'(fall_cyc), 32'(start + 33));

    // Reset at data byte 20
    send_frame(64, 8'h60, 0, 0, 0, 20, 0);
    chk("midrst_tx_en", 32'(gmii_tx_en), 32'd0);
    chk("midrst_tx_er", 32'(gmii_tx_er), 32'd0);
    chk("midrst_state", 32'(rs_tx_fsm_state), 32'd0);
    chk("midrst_ucnt", 32'(rs_tx_underrun_cnt), 32'd0);
    chk("midrst_queue", 32'(exp_q.size()), 32'd0);
    idle(3);
    start = cyc;
    send_frame(16, 8'h70, 0, 0, 0, 0, 0);
    idle(20);
    chk("postrst_rise", 32'(rise_cyc), 32'(start + 1));

    // Valid without sop in IDLE is held
    rs_tx_valid = 1'b1;
    rs_tx_data  = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      chk("nosop_ready", 32'(rs_tx_ready), 32'd0);
      tick();
      chk("nosop_tx_en", 32'(gmii_tx_en), 32'd0);
    end
    clear_inputs();

    // Pending sop with config_rs_tx_en=0, then enable
    config_rs_tx_en = 1'b0;
    rs_tx_valid     = 1'b1;
    rs_tx_sop       = 1'b1;
    rs_tx_data      = 8'h91;
    for (int k = 0; k < 4; k++) begin
      chk("dis_ready", 32'(rs_tx_ready), 32'd0);
      tick();
      chk("dis_tx_en", 32'(gmii_tx_en), 32'd0);
    end
    config_rs_tx_en = 1'b1;
    start = cyc;
    send_frame(12, 8'h90, 0, 0, 0, 0, 0);
    idle(20);
    chk("en_rise", 32'(rise_cyc), 32'(start + 1));

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/peg_l2_rs_tx.md
PEG_L2_RS_TX -- requirements
Module: peg_l2_rs_tx

Interface
REQ-001 SHALL have parameter PKT_DATA_W, default 8, packet/GMII data width; only 8 is supported.
REQ-002 SHALL have parameter IPG_W, default 8, width of the IPG config field.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port rst, input, 1; one clock, and reset is synchronous and active-high.
REQ-005 SHALL have port config_rs_tx_en, input, 1, enables frame start; sampled only in IDLE.
REQ-006 SHALL have port config_rs_tx_ipg, input, IPG_W, inter-packet gap in byte times; values below 12 are treated as 12.
REQ-007 SHALL have port rs_tx_valid, input, 1, upstream beat valid.
REQ-008 SHALL have port rs_tx_sop, input, 1, first beat of frame.
REQ-009 SHALL have port rs_tx_eop, input, 1, last beat of frame.
REQ-010 SHALL have port rs_tx_error, input, 1, upstream marks the beat as errored.
REQ-011 SHALL have port rs_tx_data, input, PKT_DATA_W, frame byte (DA first, FCS last, as produced by the MAC TX framer).
REQ-012 SHALL have port rs_tx_ready, output, 1, beat accepted when valid&ready.
REQ-013 SHALL have port gmii_txd, output, 8, GMII transmit data.
REQ-014 SHALL have port gmii_tx_en, output, 1, GMII transmit enable.
REQ-015 SHALL have port gmii_tx_er, output, 1, GMII transmit error.
REQ-016 SHALL have port rs_tx_fsm_state, output, 3, current FSM state encoding.
REQ-017 SHALL have port rs_tx_underrun_cnt, output, 16, saturating count of aborted frames.

Function
REQ-018 SHALL implement states IDLE, PRE, SFD, DATA, FLUSH and IPG.
REQ-019 SHALL register gmii_txd, gmii_tx_en and gmii_tx_er; rs_tx_ready SHALL be combinational from the state: 1 in SFD, DATA and FLUSH, 0 otherwise.
REQ-020 IDLE SHALL move to PRE when config_rs_tx_en=1 and rs_tx_valid=1 and rs_tx_sop=1 (cycle t); the beat is not consumed at t.
REQ-021 SHALL drive txd=0x55 with tx_en=1 during t+1..t+7, then txd=0xD5 with tx_en=1 at t+8.
REQ-022 SHALL consume the sop beat in the SFD cycle (t+8) and drive it on gmii_txd at t+9; in DATA, a beat accepted at cycle k appears at k+1.
REQ-023 An accepted beat with rs_tx_error=1 SHALL drive gmii_tx_er=1 with its byte.
REQ-024 An accepted beat with sop=1 while in DATA SHALL be transmitted with gmii_tx_er=1 and SHALL NOT restart the preamble.
REQ-025 Underrun: rs_tx_valid=0 in SFD or DATA at cycle k SHALL drive tx_en=1, tx_er=1, txd=0x00 at k+1, then tx_en=0; the FSM SHALL enter FLUSH and rs_tx_underrun_cnt SHALL increment, saturating at 0xFFFF.
REQ-026 FLUSH SHALL discard accepted beats with tx_en=0 until the eop beat is accepted, then enter IPG.
REQ-027 When the eop beat is accepted at cycle k, its byte SHALL appear at k+1, tx_en SHALL be 0 from k+2, and the FSM SHALL enter IPG.
REQ-028 IPG SHALL hold tx_en=0 for max(config_rs_tx_ipg,12) cycles counted from the first tx_en=0 cycle, then return to IDLE; sop may be accepted in that IDLE cycle.
REQ-029 config_rs_tx_en deasserted mid-frame SHALL NOT affect the current frame.
REQ-030 With tx_en=0, gmii_txd SHALL be 0x00 and gmii_tx_er SHALL be 0.
REQ-031 A valid beat without sop in IDLE SHALL be held (ready=0) and not dropped; upstream frames are sop-aligned.

Reset
REQ-032 On rst=1 at a clock edge, the FSM SHALL enter IDLE, gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, rs_tx_underrun_cnt=0, and the IPG and preamble counters SHALL be cleared.
REQ-033 Reset mid-frame SHALL deassert tx_en on the following cycle with no tx_er pulse.

Structure
REQ-034 Package peg_l2_rs_pkg SHALL hold the state enum, PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, PREAMBLE_LEN=7 and MIN_IPG=12.
REQ-035 The block SHALL be a single module with no sub-modules; preamble and IPG SHALL share one down-counter.

Verification
REQ-036 64-byte frame, ipg=12 -> sop at t, seven 0x55, 0xD5 at t+8, 64 data bytes at t+9..t+72, tx_en=0 from t+73.
REQ-037 Back-to-back frames, valid held high, ipg=12 and ipg=20 -> exactly 12 and 20 tx_en=0 cycles between frames; ipg=5 -> 12.
REQ-038 Valid dropped after data byte 10 -> byte 11 time shows tx_er=1, txd=0x00; remaining beats flushed; underrun_cnt=1; next frame unaffected.
REQ-039 rs_tx_error=1 on byte 30 -> gmii_tx_er=1 only on that byte.
REQ-040 rst asserted at data byte 20 -> tx_en=0 on the next cycle, state IDLE, counter=0; the next sop gives a full preamble.
REQ-041 config_rs_tx_en=0 with a pending sop -> no tx_en and ready=0; setting it to 1 -> preamble starts the next cycle.
